// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: control-word bit positions, writeback
// select codes, load/store fn3 encodings and the bus FSM state type.
package memory_stage_pkg;

    localparam int CTR_LOAD       = 0;
    localparam int CTR_STORE      = 1;
    localparam int CTR_REG_WRITE  = 2;
    localparam int CTR_WB_SEL_LSB = 3;
    localparam int CTR_WB_SEL_MSB = 4;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC   = 2'b10;

    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;
    localparam logic [2:0] FN3_SB  = 3'b000;
    localparam logic [2:0] FN3_SH  = 3'b001;
    localparam logic [2:0] FN3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Halfword accesses need a[0]=0, word accesses need a[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] fn3, input logic [1:0] addr_lo);
        return ((fn3[1:0] == FN3_LH[1:0]) && addr_lo[0]) ||
               ((fn3[1:0] == FN3_LW[1:0]) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane
// extraction with sign or zero extension.
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  fn3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] lane;

    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (fn3_i[1:0])
            FN3_SB[1:0]: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            FN3_SH[1:0]: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (fn3_i)
            FN3_LB:  load_data_o = {{24{lane[7]}}, lane[7:0]};
            FN3_LH:  load_data_o = {{16{lane[15]}}, lane[15:0]};
            FN3_LW:  load_data_o = rdata_i;
            FN3_LBU: load_data_o = {24'd0, lane[7:0]};
            FN3_LHU: load_data_o = {16'd0, lane[15:0]};
            default: load_data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: drives a single-outstanding data bus transaction for
// loads/stores, detects misalignment and bus timeouts, and registers writeback.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        invalidate,
    input  logic [5:0]  ctr_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] alu_in,
    input  logic [29:0] inc_pc_in,
    input  logic [31:0] rs2_in,
    input  logic        branch_in,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [29:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stall_out,
    output logic        redirect_out,
    output logic [29:0] redirect_pc,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  trap_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        killed_q, killed_d;
    logic        squash_q, squash_d;
    logic [1:0]  trap_q, trap_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [2:0]  fn3;
    logic [4:0]  rd;
    logic        mem_op, misaligned, start_mem, timeout, drop;
    logic [31:0] load_data, wb_src;
    logic        unused_bits;

    assign fn3        = inst_in[14:12];
    assign rd         = inst_in[11:7];
    assign mem_op     = ctr_in[CTR_LOAD] | ctr_in[CTR_STORE];
    assign misaligned = mem_op && is_misaligned(fn3, alu_in[1:0]);
    assign start_mem  = (state_q == ST_IDLE) && mem_op && !misaligned && !invalidate && !squash_q;
    assign timeout    = (state_q == ST_REQ) && !dbus_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drop       = killed_q | invalidate;

    // Upstream stays frozen while a transaction is pending, so bus fields come straight from the inputs.
    assign dbus_req     = (state_q == ST_REQ);
    assign dbus_we      = dbus_req && ctr_in[CTR_STORE];
    assign dbus_addr    = alu_in[31:2];
    assign stall_out    = rst_n && (start_mem || (state_q == ST_REQ));
    assign redirect_out = branch_in && !invalidate && !stall_out;
    assign redirect_pc  = alu_in[31:2];
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign trap_out     = trap_q;
    assign unused_bits  = ^{ctr_in[5], inst_in[31:15], inst_in[6:0]};

    load_store_align u_align (
        .fn3_i        (fn3),
        .addr_lo_i    (alu_in[1:0]),
        .store_data_i (rs2_in),
        .rdata_i      (rdata_q),
        .be_o         (dbus_be),
        .wdata_o      (dbus_wdata),
        .load_data_o  (load_data)
    );

    always_comb begin
        case (ctr_in[CTR_WB_SEL_MSB:CTR_WB_SEL_LSB])
            WB_SEL_ALU:  wb_src = alu_in;
            WB_SEL_LOAD: wb_src = load_data;
            WB_SEL_PC:   wb_src = {inc_pc_in, 2'b00};
            default:     wb_src = 32'd0;
        endcase
    end

    // squash_q marks an instruction whose aborted transaction must retire without re-issuing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        killed_d  = killed_q;
        squash_d  = squash_q;
        trap_d    = 2'b00;
        rdata_d   = rdata_q;
        wb_we_d   = wb_we_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_mem) begin
                    state_d  = ST_REQ;
                    cnt_d    = '0;
                    killed_d = 1'b0;
                    if (clk_en) wb_we_d = 1'b0;
                end else if (clk_en) begin
                    squash_d  = 1'b0;
                    trap_d[0] = misaligned && !invalidate && !squash_q;
                    wb_we_d   = ctr_in[CTR_REG_WRITE] && (rd != 5'd0) && !invalidate &&
                                !misaligned && !squash_q;
                    wb_rd_d   = rd;
                    wb_data_d = wb_src;
                end
            end
            ST_REQ: begin
                if (clk_en) wb_we_d = 1'b0;
                killed_d = drop;
                if (dbus_ack) begin
                    rdata_d = dbus_rdata;
                    if (drop) begin
                        state_d  = ST_IDLE;
                        squash_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    squash_d  = 1'b1;
                    trap_d[1] = !drop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (clk_en) begin
                    state_d   = ST_IDLE;
                    wb_we_d   = ctr_in[CTR_REG_WRITE] && (rd != 5'd0) && !invalidate;
                    wb_rd_d   = rd;
                    wb_data_d = wb_src;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            killed_q  <= 1'b0;
            squash_q  <= 1'b0;
            trap_q    <= 2'b00;
            rdata_q   <= 32'd0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            killed_q  <= killed_d;
            squash_q  <= squash_d;
            trap_q    <= trap_d;
            rdata_q   <= rdata_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a table of single-cycle vectors followed
// by hand-written bus sequences (stores, loads, timeout, invalidate, reset, clk_en).
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        invalidate = 1'b0;
    logic [5:0]  ctr_in = '0;
    logic [31:0] inst_in = '0;
    logic [31:0] alu_in = '0;
    logic [29:0] inc_pc_in = '0;
    logic [31:0] rs2_in = '0;
    logic        branch_in = 1'b0;
    logic        dbus_req, dbus_we;
    logic [29:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata = '0;
    logic        dbus_ack = 1'b0;
    logic        stall_out, redirect_out;
    logic [29:0] redirect_pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  trap_out;

    int compared = 0;
    int mismatched = 0;

    memory_stage #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .invalidate(invalidate),
        .ctr_in(ctr_in), .inst_in(inst_in), .alu_in(alu_in), .inc_pc_in(inc_pc_in),
        .rs2_in(rs2_in), .branch_in(branch_in),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .stall_out(stall_out), .redirect_out(redirect_out), .redirect_pc(redirect_pc),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .trap_out(trap_out)
    );

    always #5 clk = ~clk;

    // One comparison: bump the counters and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive all pipeline-side inputs at once; the bus ack is always released.
    task automatic applyStimulus(input logic [5:0] c, input logic [31:0] i, input logic [31:0] a,
                                 input logic [29:0] pc, input logic [31:0] r2,
                                 input logic br, input logic inv);
        ctr_in = c; inst_in = i; alu_in = a; inc_pc_in = pc; rs2_in = r2;
        branch_in = br; invalidate = inv; dbus_ack = 1'b0;
    endtask

    // Walks a memory op from its IDLE cycle until stall drops, acking on the given REQ cycle
    // (0 = never) and checking the bus fields on every REQ cycle.
    task automatic runMem(input string name, input logic [29:0] expAddr, input logic isSt,
                          input logic [3:0] expBe, input logic [31:0] expWdata,
                          input logic [31:0] rdata, input int ackAt,
                          output int stallCycles, output int reqCycles, output logic [1:0] trapAtRelease);
        logic released;
        stallCycles = 0;
        reqCycles = 0;
        released = 1'b0;
        for (int n = 0; n < 400; n++) begin
            #1;
            dbus_ack = 1'b0;
            if (!stall_out) begin
                released = 1'b1;
                break;
            end
            stallCycles++;
            if (dbus_req) begin
                reqCycles++;
                checkOutput({name, "_addr"}, 32'(dbus_addr), 32'(expAddr));
                checkOutput({name, "_we"}, 32'(dbus_we), 32'(isSt));
                if (isSt) begin
                    checkOutput({name, "_be"}, 32'(dbus_be), 32'(expBe));
                    checkOutput({name, "_wdata"}, dbus_wdata, expWdata);
                end
                dbus_ack = (reqCycles == ackAt);
                dbus_rdata = rdata;
            end
            @(negedge clk);
        end
        if (!released) checkOutput({name, "_stall_release"}, 32'd0, 32'd1);
        trapAtRelease = trap_out;
    endtask

    // Aligned load acked on its first REQ cycle, then writeback is checked.
    task automatic doLoad(input string name, input logic [2:0] fn3, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] expData);
        int sc, rc;
        logic [1:0] tr;
        @(negedge clk);
        applyStimulus(6'h0D, {17'd0, fn3, rd, 7'd0}, a, 30'd0, 32'd0, 1'b0, 1'b0);
        runMem(name, a[31:2], 1'b0, 4'h0, 32'd0, rdata, 1, sc, rc, tr);
        checkOutput({name, "_stall_cycles"}, 32'(sc), 32'd2);
        checkOutput({name, "_trap"}, 32'(tr), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, "_wb_we"}, 32'(wb_we), 32'd1);
        checkOutput({name, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        checkOutput({name, "_wb_data"}, wb_data, expData);
    endtask

    task automatic doStore(input string name, input logic [2:0] fn3, input logic [31:0] a,
                           input logic [31:0] rs2, input logic [3:0] expBe, input logic [31:0] expWdata,
                           input int ackAt, input int expStall);
        int sc, rc;
        logic [1:0] tr;
        @(negedge clk);
        applyStimulus(6'h02, {17'd0, fn3, 5'd0, 7'd0}, a, 30'd0, rs2, 1'b0, 1'b0);
        runMem(name, a[31:2], 1'b1, expBe, expWdata, 32'd0, ackAt, sc, rc, tr);
        checkOutput({name, "_stall_cycles"}, 32'(sc), 32'(expStall));
        checkOutput({name, "_req_cycles"}, 32'(rc), 32'(ackAt));
        @(posedge clk); #1;
        checkOutput({name, "_wb_we"}, 32'(wb_we), 32'd0);
    endtask

    typedef struct {
        logic [5:0]  ctr;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [29:0] incPc;
        logic        branch;
        logic        inv;
        logic        expStall;
        logic        expRedirect;
        logic [29:0] expRedirPc;
        logic        expWbWe;
        logic [4:0]  expRd;
        logic        chkData;
        logic [31:0] expData;
        logic [1:0]  expTrap;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int sc, rc;
        logic [1:0] tr;

        // Single-cycle behaviour: ALU/PC writeback, redirects, misalignment traps, invalidation.
        vecs[0]  = '{6'h04, 32'h0000_0280, 32'h1234_5678, 30'h0,    1'b0, 1'b0, 1'b0, 1'b0, 30'h0,   1'b1, 5'd5,  1'b1, 32'h1234_5678, 2'b00};
        vecs[1]  = '{6'h04, 32'h0000_0000, 32'hAAAA_5555, 30'h0,    1'b0, 1'b0, 1'b0, 1'b0, 30'h0,   1'b0, 5'd0,  1'b0, 32'h0,         2'b00};
        vecs[2]  = '{6'h14, 32'h0000_0F80, 32'h0000_2000, 30'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 30'h800, 1'b1, 5'd31, 1'b1, 32'h0000_48D0, 2'b00};
        vecs[3]  = '{6'h04, 32'h0000_0180, 32'h0000_0005, 30'h0,    1'b1, 1'b1, 1'b0, 1'b0, 30'h0,   1'b0, 5'd3,  1'b0, 32'h0,         2'b00};
        vecs[4]  = '{6'h0D, 32'h0000_2380, 32'h0000_0102, 30'h0,    1'b0, 1'b0, 1'b0, 1'b0, 30'h0,   1'b0, 5'd7,  1'b0, 32'h0,         2'b01};
        vecs[5]  = '{6'h00, 32'h0000_0000, 32'h0000_0000, 30'h0,    1'b0, 1'b0, 1'b0, 1'b0, 30'h0,   1'b0, 5'd0,  1'b0, 32'h0,         2'b00};
        vecs[6]  = '{6'h02, 32'h0000_1000, 32'h0000_0101, 30'h0,    1'b0, 1'b0, 1'b0, 1'b0, 30'h0,   1'b0, 5'd0,  1'b0, 32'h0,         2'b01};
        vecs[7]  = '{6'h0D, 32'h0000_1400, 32'h0000_0103, 30'h0,    1'b0, 1'b0, 1'b0, 1'b0, 30'h0,   1'b0, 5'd8,  1'b0, 32'h0,         2'b01};
        vecs[8]  = '{6'h0D, 32'h0000_2380, 32'h0000_0102, 30'h0,    1'b0, 1'b1, 1'b0, 1'b0, 30'h0,   1'b0, 5'd7,  1'b0, 32'h0,         2'b00};
        vecs[9]  = '{6'h0D, 32'h0000_2380, 32'h0000_0100, 30'h0,    1'b0, 1'b1, 1'b0, 1'b0, 30'h0,   1'b0, 5'd7,  1'b0, 32'h0,         2'b00};
        vecs[10] = '{6'h04, 32'h0000_0080, 32'h0000_0104, 30'h0,    1'b1, 1'b0, 1'b0, 1'b1, 30'h41,  1'b1, 5'd1,  1'b1, 32'h0000_0104, 2'b00};

        // Reset state while rst_n is held low.
        #1;
        checkOutput("rst_dbus_req", 32'(dbus_req), 32'd0);
        checkOutput("rst_dbus_we", 32'(dbus_we), 32'd0);
        checkOutput("rst_stall", 32'(stall_out), 32'd0);
        checkOutput("rst_wb_we", 32'(wb_we), 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_trap", 32'(trap_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].ctr, vecs[i].inst, vecs[i].alu, vecs[i].incPc, 32'd0,
                          vecs[i].branch, vecs[i].inv);
            #1;
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall_out), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d_redirect", i), 32'(redirect_out), 32'(vecs[i].expRedirect));
            if (vecs[i].expRedirect)
                checkOutput($sformatf("vec%0d_redirect_pc", i), 32'(redirect_pc), 32'(vecs[i].expRedirPc));
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_wb_we", i), 32'(wb_we), 32'(vecs[i].expWbWe));
            checkOutput($sformatf("vec%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].expRd));
            if (vecs[i].chkData)
                checkOutput($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d_trap", i), 32'(trap_out), 32'(vecs[i].expTrap));
            checkOutput($sformatf("vec%0d_dbus_req", i), 32'(dbus_req), 32'd0);
        end

        // Stores: lane steering and stall length versus ack latency.
        doStore("sw", 3'b010, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 3, 4);
        doStore("sb", 3'b000, 32'h101, 32'h0000_00A5, 4'h2, 32'hA5A5_A5A5, 1, 2);
        doStore("sh_hi", 3'b001, 32'h102, 32'h1234_BEEF, 4'hC, 32'hBEEF_BEEF, 2, 3);
        doStore("sh_lo", 3'b001, 32'h100, 32'h1234_BEEF, 4'h3, 32'hBEEF_BEEF, 1, 2);

        // Loads: lane select with sign/zero extension.
        doLoad("lb", 3'b000, 32'h103, 5'd9, 32'h80FF_FFFF, 32'hFFFF_FF80);
        doLoad("lbu", 3'b100, 32'h103, 5'd9, 32'h80FF_FFFF, 32'h0000_0080);
        doLoad("lhu", 3'b101, 32'h102, 5'd10, 32'h80FF_FFFF, 32'h0000_80FF);
        doLoad("lh", 3'b001, 32'h102, 5'd11, 32'h80FF_0000, 32'hFFFF_80FF);
        doLoad("lw", 3'b010, 32'h100, 5'd12, 32'h1357_9BDF, 32'h1357_9BDF);
        doLoad("lb_pos", 3'b000, 32'h100, 5'd13, 32'h0000_007F, 32'h0000_007F);

        // Bus timeout: no ack for 255 REQ cycles.
        @(negedge clk);
        applyStimulus(6'h0D, 32'h0000_2280, 32'h200, 30'd0, 32'd0, 1'b0, 1'b0);
        runMem("timeout", 30'h80, 1'b0, 4'h0, 32'd0, 32'd0, 0, sc, rc, tr);
        checkOutput("timeout_req_cycles", 32'(rc), 32'd255);
        checkOutput("timeout_stall_cycles", 32'(sc), 32'd256);
        checkOutput("timeout_trap", 32'(tr), 32'd2);
        checkOutput("timeout_req_dropped", 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
        checkOutput("timeout_wb_we", 32'(wb_we), 32'd0);
        checkOutput("timeout_trap_pulse_end", 32'(trap_out), 32'd0);

        // Invalidate during REQ: request held to the ack, result discarded.
        @(negedge clk);
        applyStimulus(6'h0D, 32'h0000_2200, 32'h100, 30'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("inv_req1", 32'(dbus_req), 32'd1);
        invalidate = 1'b1;
        @(posedge clk); #1;
        invalidate = 1'b0;
        checkOutput("inv_req2", 32'(dbus_req), 32'd1);
        @(posedge clk); #1;
        checkOutput("inv_req3", 32'(dbus_req), 32'd1);
        dbus_rdata = 32'h5555_AAAA;
        dbus_ack = 1'b1;
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        checkOutput("inv_req_after_ack", 32'(dbus_req), 32'd0);
        checkOutput("inv_stall_after_ack", 32'(stall_out), 32'd0);
        checkOutput("inv_trap", 32'(trap_out), 32'd0);
        @(posedge clk); #1;
        checkOutput("inv_wb_we", 32'(wb_we), 32'd0);
        checkOutput("inv_trap_late", 32'(trap_out), 32'd0);

        // Asynchronous reset in the middle of a store transaction.
        @(negedge clk);
        applyStimulus(6'h02, 32'h0000_2000, 32'h100, 30'd0, 32'h0BAD_F00D, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("rstmid_req_before", 32'(dbus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_dbus_req", 32'(dbus_req), 32'd0);
        checkOutput("rstmid_dbus_we", 32'(dbus_we), 32'd0);
        checkOutput("rstmid_stall", 32'(stall_out), 32'd0);
        checkOutput("rstmid_wb_we", 32'(wb_we), 32'd0);
        checkOutput("rstmid_wb_data", wb_data, 32'd0);
        checkOutput("rstmid_trap", 32'(trap_out), 32'd0);
        applyStimulus(6'h00, 32'd0, 32'd0, 30'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // clk_en low: the bus FSM still completes but writeback holds until clk_en returns.
        @(negedge clk);
        applyStimulus(6'h04, 32'h0000_0100, 32'h0000_0011, 30'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("clken_pre_wb_rd", 32'(wb_rd), 32'd2);
        @(negedge clk);
        clk_en = 1'b0;
        applyStimulus(6'h0D, 32'h0000_2300, 32'h104, 30'd0, 32'd0, 1'b0, 1'b0);
        runMem("clken", 30'h41, 1'b0, 4'h0, 32'd0, 32'hCAFE_F00D, 1, sc, rc, tr);
        checkOutput("clken_stall_cycles", 32'(sc), 32'd2);
        @(posedge clk); #1;
        checkOutput("clken_hold_stall", 32'(stall_out), 32'd0);
        checkOutput("clken_hold_wb_we", 32'(wb_we), 32'd1);
        checkOutput("clken_hold_wb_rd", 32'(wb_rd), 32'd2);
        checkOutput("clken_hold_wb_data", wb_data, 32'h0000_0011);
        clk_en = 1'b1;
        @(posedge clk); #1;
        checkOutput("clken_wb_we", 32'(wb_we), 32'd1);
        checkOutput("clken_wb_rd", 32'(wb_rd), 32'd6);
        checkOutput("clken_wb_data", wb_data, 32'hCAFE_F00D);
        @(negedge clk);
        applyStimulus(6'h00, 32'd0, 32'd0, 30'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop in case something stalls the stimulus process.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
